// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the off-chip memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam logic REQ_DCACHE = 1'b0;
    localparam logic REQ_IFETCH = 1'b1;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 256;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not served last.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic gnt_o,
    output logic any_req_o
);

    always_comb begin
        any_req_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            gnt_o = ~last_grant_i;
        end else if (req1_i) begin
            gnt_o = REQ_IFETCH;
        end else begin
            gnt_o = REQ_DCACHE;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the data cache and instruction-fetch refill paths onto the single
// 256-bit memory port, sequencing one line transfer at a time with a timeout.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic [DATA_W-1:0] m0_data_o,
    output logic              m0_ack_o,

    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              m1_ack_o,

    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,

    output logic              busy_o,
    output logic              timeout_o
);

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e        state_q;
    logic              last_grant_q;
    logic              gnt_q;
    logic              cmd_write_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [DATA_W-1:0] cmd_data_q;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              mem_en_q;
    logic              m0_ack_q;
    logic              m1_ack_q;
    logic              busy_q;
    logic              timeout_q;

    logic              rr_gnt;
    logic              rr_any;

    mem_arb_rr u_rr (
        .req0_i       (m0_enable_i),
        .req1_i       (m1_enable_i),
        .last_grant_i (last_grant_q),
        .gnt_o        (rr_gnt),
        .any_req_o    (rr_any)
    );

    // last_grant resets to m1 so that m0 wins the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_IFETCH;
            gnt_q        <= REQ_DCACHE;
            cmd_write_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_data_q   <= '0;
            rdata_q      <= '0;
            cnt_q        <= '0;
            mem_en_q     <= 1'b0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rr_any) begin
                        gnt_q        <= rr_gnt;
                        last_grant_q <= rr_gnt;
                        cmd_write_q  <= rr_gnt ? m1_write_i : m0_write_i;
                        cmd_addr_q   <= rr_gnt ? m1_addr_i  : m0_addr_i;
                        cmd_data_q   <= rr_gnt ? m1_data_i  : m0_data_i;
                        cnt_q        <= '0;
                        mem_en_q     <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= BUSY;
                    end
                end
                BUSY: begin
                    // An ack on the final counted cycle still completes normally.
                    if (mem_ack_i) begin
                        if (!cmd_write_q) begin
                            rdata_q <= mem_data_i;
                        end
                        mem_en_q <= 1'b0;
                        m0_ack_q <= (gnt_q == REQ_DCACHE);
                        m1_ack_q <= (gnt_q == REQ_IFETCH);
                        state_q  <= RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        timeout_q <= 1'b1;
                        rdata_q   <= '0;
                        mem_en_q  <= 1'b0;
                        m0_ack_q  <= (gnt_q == REQ_DCACHE);
                        m1_ack_q  <= (gnt_q == REQ_IFETCH);
                        state_q   <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    m0_ack_q <= 1'b0;
                    m1_ack_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    mem_en_q <= 1'b0;
                    m0_ack_q <= 1'b0;
                    m1_ack_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign mem_enable_o = mem_en_q;
    assign mem_write_o  = cmd_write_q;
    assign mem_addr_o   = cmd_addr_q;
    assign mem_data_o   = cmd_data_q;
    assign m0_ack_o     = m0_ack_q;
    assign m1_ack_o     = m1_ack_q;
    assign m0_data_o    = rdata_q;
    assign m1_data_o    = rdata_q;
    assign busy_o       = busy_q;
    assign timeout_o    = timeout_q;

endmodule
